// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath: accumulator FSM states, default
// widths and the accumulator width derivation.
package pe_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_HOLD  = 2'd2
  } acc_state_t;

  localparam int DEF_PROD_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 9;

  // Product counter width; a window is force-closed when it reaches all ones.
  localparam int CNT_WIDTH = 8;

  // Accumulator wide enough to hold KERNEL_SIZE full-scale products.
  function automatic int acc_width(input int prod_width, input int kernel_size);
    return prod_width + $clog2(kernel_size);
  endfunction

endpackage

// File: rtl/pe_acc_out_reg.sv
// One-entry valid/ready result register for pe_accumulator.
// Loads a window result, holds it while the consumer stalls, clears on accept.
module pe_acc_out_reg #(
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] load_sum,
  input  logic                 load_occupied,
  input  logic                 load_count_err,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_occupied,
  output logic                 out_count_err
);

  // Load wins over accept so a result leaving this cycle can be replaced at once.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_occupied  <= 1'b0;
      out_count_err <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_sum       <= load_sum;
      out_occupied  <= load_occupied;
      out_count_err <= load_count_err;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_occupied  <= 1'b0;
      out_count_err <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_accumulator.sv
// Window accumulator for the PE: sums one kernel window of products, compares
// the total with a threshold and presents it through a valid/ready register.
// Build option: define ACC_SATURATE_EN to clamp the accumulator at full scale
// (and force out_occupied) instead of wrapping modulo 2^ACC_WIDTH.
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int PROD_WIDTH  = DEF_PROD_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int ACC_WIDTH   = acc_width(PROD_WIDTH, KERNEL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  acc_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_product,
  input  logic                  in_last,
  input  logic [ACC_WIDTH-1:0]  threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_occupied,
  output logic                  out_count_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] KERNEL_CNT = CNT_WIDTH'(KERNEL_SIZE);

  acc_state_t           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 xfer;
  logic                 accept;
  logic                 start_win;
  logic [ACC_WIDTH-1:0] sum_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 clamp_next;
  logic                 force_close;
  logic                 close_win;
  logic                 occupied_next;
  logic                 count_err_next;

  // out_ready feeds in_ready directly so a held result and a new product can
  // swap in the same cycle; reset gates it so nothing is accepted in reset.
  assign in_ready  = rstn && acc_en && (state != ACC_HOLD || out_ready);
  assign xfer      = in_valid && in_ready;
  assign accept    = out_valid && out_ready;
  // A transfer outside ACCUM always opens a fresh window.
  assign start_win = (state != ACC_ACCUM);

`ifdef ACC_SATURATE_EN
  logic                 clamped;
  logic [ACC_WIDTH:0]   sum_wide;
`endif

  // Next accumulator value, count and the result that would be loaded.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_next   = start_win ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
`ifdef ACC_SATURATE_EN
    sum_wide   = {1'b0, (start_win ? '0 : acc)} + {1'b0, ACC_WIDTH'(in_product)};
    sum_next   = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
    clamp_next = sum_wide[ACC_WIDTH] || (!start_win && clamped);
`else
    sum_next   = (start_win ? '0 : acc) + ACC_WIDTH'(in_product);
    clamp_next = 1'b0;
`endif
    force_close    = !in_last && (cnt_next == CNT_MAX);
    close_win      = xfer && (in_last || force_close);
    occupied_next  = (sum_next >= threshold) || clamp_next;
    count_err_next = force_close || (cnt_next != KERNEL_CNT);
  end

  // Window FSM and accumulator; everything here moves only on a transfer,
  // except HOLD draining to IDLE once its result is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ACC_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (xfer) begin
      acc   <= sum_next;
      cnt   <= cnt_next;
      state <= close_win ? ACC_HOLD : ACC_ACCUM;
    end else if (state == ACC_HOLD && accept) begin
      state <= ACC_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end
  end

`ifdef ACC_SATURATE_EN
  // Remembers that the current window clamped so the occupied flag is forced.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clamped <= 1'b0;
    end else if (xfer) begin
      clamped <= clamp_next;
    end else if (state == ACC_HOLD && accept) begin
      clamped <= 1'b0;
    end
  end
`endif

  pe_acc_out_reg #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_out_reg (
    .clk            (clk),
    .rstn           (rstn),
    .load           (close_win),
    .load_sum       (sum_next),
    .load_occupied  (occupied_next),
    .load_count_err (count_err_next),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_sum        (out_sum),
    .out_occupied   (out_occupied),
    .out_count_err  (out_count_err)
  );

endmodule

// File: tb/tb_pe_accumulator.sv
// Self-checking bench for pe_accumulator: a table of directed windows, hand
// sequences for latency, backpressure, enable and reset, and random windows
// checked against a window-level sum/threshold model.
module tb_pe_accumulator;

  localparam int AW = 20;
  localparam int KS = 9;

  typedef struct {
    logic [AW-1:0] sum;
    logic          occ;
    logic          err;
  } exp_t;

  typedef struct {
    int            n;
    int            first;
    int            step;
    logic [AW-1:0] thr;
    logic [AW-1:0] sum;
    logic          occ;
    logic          err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          acc_en;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_product;
  logic          in_last;
  logic [AW-1:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_occupied;
  logic          out_count_err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   cur_win[$];
  bit   rand_bp    = 1'b0;
  bit   table_mode = 1'b0;

  pe_accumulator dut (
    .clk           (clk),
    .rstn          (rstn),
    .acc_en        (acc_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_product    (in_product),
    .in_last       (in_last),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_occupied  (out_occupied),
    .out_count_err (out_count_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a window is the list of accepted products; it closes on
  // in_last or when it holds 255 products.
  function automatic void model_accept(input int p, input logic last);
    longint total;
    exp_t   e;
    total = 0;
    cur_win.push_back(p);
    if (last || cur_win.size() == 255) begin
      foreach (cur_win[i]) total += longint'(cur_win[i]);
`ifdef ACC_SATURATE_EN
      if (total > longint'((1 << AW) - 1)) begin
        e.sum = '1;
        e.occ = 1'b1;
      end else begin
        e.sum = AW'(total);
        e.occ = (e.sum >= threshold);
      end
`else
      e.sum = AW'(total % (longint'(1) << AW));
      e.occ = (e.sum >= threshold);
`endif
      e.err = (cur_win.size() != KS);
      if (!table_mode) exp_q.push_back(e);
      cur_win.delete();
    end
  endfunction

  // Result monitor: a result is consumed when out_valid && out_ready before the edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_occupied", 32'(out_occupied), 32'(e.occ));
        check("out_count_err", 32'(out_count_err), 32'(e.err));
      end
    end
  end

  task automatic randomize_ctl();
    out_ready = ($urandom_range(0, 3) != 0);
    acc_en    = ($urandom_range(0, 4) != 0);
  endtask

  // Offers one product from posedge+1 and returns at posedge+1 after it transfers.
  task automatic send(input logic [15:0] p, input logic last, output int stalls);
    int waited;
    waited = 0;
    if (rand_bp) randomize_ctl();
    in_product = p;
    in_last    = last;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(posedge clk);
      #1;
      if (rand_bp) randomize_ctl();
      @(negedge clk);
    end
    stalls = waited;
    if (!in_ready) begin
      check("send_timeout", 32'(waited), 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_accept(int'(p), last);
    end
  endtask

  task automatic send_window(input int first, input int step, input int n, input logic close,
                             output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send(16'(first + i * step), close && (i == n - 1), s);
      stalls += s;
    end
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    out_ready = 1'b1;
    acc_en    = 1'b1;
    while (exp_q.size() != 0 && i < 50) begin
      @(posedge clk);
      i++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    check({tag, "_out_occupied"}, 32'(out_occupied), 32'd0);
    check({tag, "_out_count_err"}, 32'(out_count_err), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int   s;
    int   total_stalls;
    int   len;

    tbl[0] = '{9, 65025, 0, 20'd585225, 20'd585225, 1'b1, 1'b0};
    tbl[1] = '{9, 65025, 0, 20'd585226, 20'd585225, 1'b0, 1'b0};
    tbl[2] = '{9, 1,     1, 20'd45,     20'd45,     1'b1, 1'b0};
    tbl[3] = '{9, 10,    1, 20'd127,    20'd126,    1'b0, 1'b0};
    tbl[4] = '{4, 1,     1, 20'd10,     20'd10,     1'b1, 1'b1};
    tbl[5] = '{1, 7,     0, 20'd0,      20'd7,      1'b1, 1'b1};
    tbl[6] = '{9, 1,     0, 20'd9,      20'd9,      1'b1, 1'b0};

    rstn       = 1'b0;
    acc_en     = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_product = '0;
    threshold  = '0;
    out_ready  = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed table, all windows back-to-back with out_ready high.
    table_mode   = 1'b1;
    total_stalls = 0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{sum: tbl[i].sum, occ: tbl[i].occ, err: tbl[i].err});
      threshold = tbl[i].thr;
      send_window(tbl[i].first, tbl[i].step, tbl[i].n, 1'b1, s);
      total_stalls += s;
    end
    check("b2b_in_ready_stalls", 32'(total_stalls), 32'd0);
    drain("table_drain");
    table_mode = 1'b0;

    // Latency: out_valid rises one cycle after the in_last transfer.
    threshold = 20'd9;
    send_window(1, 0, 8, 1'b0, s);
    in_product = 16'd1;
    in_last    = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    check("pre_last_out_valid", 32'(out_valid), 32'd0);
    check("last_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_accept(1, 1'b1);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    drain("latency_drain");

    // Backpressure: result held for 5 cycles, released by an out_ready pulse.
    out_ready = 1'b0;
    threshold = 20'd0;
    send_window(1, 1, 9, 1'b1, s);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'd45);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("released_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    drain("bp_drain");

    // acc_en dropped for 3 cycles mid-window: offered product must be ignored.
    threshold = 20'd45;
    send_window(1, 1, 3, 1'b0, s);
    acc_en     = 1'b0;
    in_valid   = 1'b1;
    in_product = 16'd99;
    in_last    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("en_low_in_ready", 32'(in_ready), 32'd0);
      check("en_low_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_en   = 1'b1;
    send_window(4, 1, 6, 1'b1, s);
    drain("en_drain");

    // Reset discards a held result.
    out_ready = 1'b0;
    threshold = 20'd0;
    send_window(1, 1, 9, 1'b1, s);
    rstn = 1'b0;
    exp_q.delete();
    cur_win.delete();
    @(negedge clk);
    check_outputs_zero("rst_held");
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_held_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset after 5 products discards the partial window.
    send_window(1, 0, 5, 1'b0, s);
    rstn = 1'b0;
    cur_win.delete();
    @(negedge clk);
    check_outputs_zero("rst_partial");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_partial_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    threshold = 20'd9;
    send_window(1, 0, 9, 1'b1, s);
    drain("rst_drain");

    // Runaway window: 255 products without in_last close with the error flag.
    threshold = 20'd300;
    send_window(1, 0, 255, 1'b0, s);
    send_window(5, 0, 1, 1'b1, s);
    drain("runaway_drain");

    // Random windows with random backpressure, enable and idle gaps.
    rand_bp = 1'b1;
    for (int w = 0; w < 40; w++) begin
      threshold = AW'($urandom_range(0, 600000));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : KS;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          randomize_ctl();
          @(posedge clk);
          #1;
        end
        send(16'($urandom_range(0, 65535)), i == len - 1, s);
      end
    end
    rand_bp = 1'b0;
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_accumulator.md
# pe_accumulator

- Downstream stage of the processing element (PE) in the map-inflation datapath.
- Consumes the PE's per-cycle products, one kernel window at a time, and sums them into a window total.
- Compares the total against a programmable threshold to decide whether the output cell is inflated (occupied).
- Hands the result to the next stage through a one-entry output register with valid/ready backpressure.

## Interface
Parameters:
- PROD_WIDTH, 16, width of one PE product (DATA_WIDTH + WEIGHT_WIDTH).
- KERNEL_SIZE, 9, products per window (3x3 kernel); legal range 2..255.
- ACC_WIDTH, PROD_WIDTH + $clog2(KERNEL_SIZE), accumulator and threshold width (20 at defaults).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous and active-low.
- acc_en  input  1  stage enable; when low, no input is accepted and internal state holds.
- in_valid  input  1  in_product/in_last are valid.
- in_ready  output  1  stage can accept a product this cycle.
- in_product  input  PROD_WIDTH  product from the PE.
- in_last  input  1  marks the final product of a window.
- threshold  input  ACC_WIDTH  cell is occupied when the sum is at least this value; sampled when the window closes.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_WIDTH  window total.
- out_occupied  output  1  out_sum >= threshold.
- out_count_err  output  1  the window's product count differed from KERNEL_SIZE.

## Operation
- Transfer occurs when in_valid && in_ready. The accumulator and count update only on a transfer.
- State machine, 2-bit:
  - IDLE: accumulator = 0, count = 0. A transfer loads acc = in_product, count = 1.
    - Goes to HOLD if in_last is set; otherwise goes to ACCUM.
  - ACCUM: a transfer performs acc += in_product and count += 1.
    - in_last goes to HOLD.
    - The count reaching 255 without in_last also goes to HOLD, with the error flag set.
  - HOLD: result register loaded with out_valid = 1. It leaves HOLD when out_valid && out_ready.
    - If a transfer occurs in the same cycle, it starts a new window: next state is ACCUM, or HOLD if in_last is set.
    - Otherwise the next state is IDLE.
- Result register loads on entry to HOLD:
  - out_sum = final accumulator value.
  - out_occupied = (final sum >= threshold), unsigned compare.
  - out_count_err = (final count != KERNEL_SIZE).
- in_ready = acc_en && (state != HOLD || out_ready). The combinational path from out_ready is intentional and supports back-to-back windows.
- Arithmetic: unsigned. in_product is zero-extended to ACC_WIDTH. Overflow behaviour is set by the configuration macro.
- acc_en low mid-window: accumulator, count and state are frozen. out_valid and the result register still follow out_ready.
- threshold changes mid-window have no effect until the window closes.

## Timing
- Reset values: in_ready 0 while rstn is low, and acc_en-dependent after release. out_valid, out_sum, out_occupied and out_count_err are all 0. State is IDLE.
- Latency: out_valid rises one cycle after the transfer carrying in_last.
- Throughput: one product per cycle. Zero bubble cycles between windows when out_ready is held high.
- Reset asserted mid-window discards the partial sum and any held result. No output is produced for that window.
- out_sum, out_occupied and out_count_err are stable while out_valid && !out_ready.

## Configuration
- ACC_SATURATE_EN defined: the accumulator clamps at 2^ACC_WIDTH-1 on overflow, and out_occupied is forced to 1 when a clamp occurred in the window.
- ACC_SATURATE_EN undefined: the accumulator wraps modulo 2^ACC_WIDTH, with no clamp logic.
- At default parameters overflow is unreachable, so the two builds are identical for legal inputs. The difference matters only when KERNEL_SIZE is exceeded.

## Structure
- Shared package pe_pkg:
  - State enum: ACC_IDLE, ACC_ACCUM, ACC_HOLD.
  - Default PROD_WIDTH and KERNEL_SIZE constants.
  - ACC_WIDTH derivation function.
- One sub-module is natural: pe_acc_out_reg, the one-entry valid/ready result register (load, hold, and clear on accept).
- The FSM and accumulator live in the top.

## Test plan
- Window of nine products, each 255*255 = 65025, threshold 585225, out_ready=1: out_sum=585225, out_occupied=1, out_count_err=0, out_valid one cycle after the last product.
- Same window with threshold 585226: out_occupied=0.
- Two windows back-to-back with products 1..9 then 10..18, out_ready=1, no gaps: sums 45 then 126; in_ready stays high throughout.
- out_ready held low for 5 cycles after a result: out_valid and out_sum held; in_ready=0 while in HOLD. out_ready pulse releases the result and in_ready rises the same cycle.
- in_last on the 4th product: out_count_err=1 with the sum of those 4. acc_en dropped for 3 cycles mid-window: the sum is unchanged versus the uninterrupted run.
- rstn pulsed low after 5 products of a window: all outputs 0, no out_valid. The next full window of 1s yields out_sum=9.
